// File: rtl/alu_md_ctrl.sv
// EX-stage ALU control decoder plus sequential RV32M multiply/divide engine with pipeline stall.
// Define ALU_MD_FAST_MUL_EN for single-cycle multiplies; divides are always iterative.
module alu_md_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      ALUop,
  input  logic [31:0]     inst,
  input  logic            req_valid,
  input  logic            kill,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic [3:0]      ALU_selection,
  output logic            is_md,
  output logic            stall,
  output logic            busy,
  output logic            md_done,
  output logic [XLEN-1:0] md_result,
  output logic [1:0]      dbg_state
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_MUL  = 2'b01;
  localparam logic [1:0] S_DIV  = 2'b10;
  localparam logic [1:0] S_DONE = 2'b11;

  logic [1:0]      r_state;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_f3;
  logic [XLEN-1:0] r_mcand;
  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  logic            r_neg;
  logic            r_done;
  logic [XLEN-1:0] r_result;

  logic [2:0]      w_f3;
  logic            w_a_signed, w_b_signed, w_sa, w_sb, w_neg;
  logic [XLEN-1:0] w_mag_a, w_mag_b;
  logic            w_div_zero, w_ovf;
  logic [XLEN-1:0] w_special;
  logic            w_unused_inst;

  assign w_f3          = inst[14:12];
  assign is_md         = (ALUop == 2'b10) && inst[25];
  assign w_unused_inst = ^{inst[31], inst[29:26], inst[24:15], inst[11:0]};

  // Handshake: the EX instruction is held (stall=1) from the first cycle it is
  // presented until the cycle md_done pulses; that cycle lets EX advance once.
  assign stall     = req_valid & is_md & ~md_done & ~kill;
  assign busy      = (r_state != S_IDLE);
  assign md_done   = r_done;
  assign md_result = r_result;
  assign dbg_state = r_state;

  always_comb begin
    ALU_selection = 4'b0000;
    case (ALUop)
      2'b00: ALU_selection = 4'b0000;
      2'b01: ALU_selection = 4'b0001;
      2'b10: begin
        if (!inst[25]) begin
          case (w_f3)
            3'b000:  ALU_selection = inst[30] ? 4'b0001 : 4'b0000;
            3'b001:  ALU_selection = 4'b1001;
            3'b010:  ALU_selection = 4'b1101;
            3'b011:  ALU_selection = 4'b1111;
            3'b100:  ALU_selection = 4'b0111;
            3'b101:  ALU_selection = inst[30] ? 4'b1010 : 4'b1000;
            3'b110:  ALU_selection = 4'b0100;
            default: ALU_selection = 4'b0101;
          endcase
        end
      end
      default: ALU_selection = 4'b0000;
    endcase
  end

  // Operand signedness per M-op; the engine only ever works on magnitudes.
  always_comb begin
    w_a_signed = 1'b0;
    w_b_signed = 1'b0;
    if (w_f3[2]) begin
      w_a_signed = ~w_f3[0];
      w_b_signed = ~w_f3[0];
    end else begin
      w_a_signed = (w_f3[1:0] == 2'b01) || (w_f3[1:0] == 2'b10);
      w_b_signed = (w_f3[1:0] == 2'b01);
    end
  end

  assign w_sa       = w_a_signed & op_a[XLEN-1];
  assign w_sb       = w_b_signed & op_b[XLEN-1];
  assign w_mag_a    = w_sa ? (~op_a + 1'b1) : op_a;
  assign w_mag_b    = w_sb ? (~op_b + 1'b1) : op_b;
  assign w_neg      = (w_f3[2] && w_f3[1]) ? w_sa : (w_sa ^ w_sb);
  assign w_div_zero = (op_b == '0);
  assign w_ovf      = ~w_f3[0] && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
  assign w_special  = w_div_zero ? (w_f3[1] ? op_a : '1) : (w_f3[1] ? '0 : op_a);

  // Shift-add multiply step: {r_hi, r_lo} shifts right as the multiplier bits are consumed.
  logic [XLEN:0]     w_msum;
  logic [XLEN-1:0]   w_mhi_nx, w_mlo_nx;
  logic [2*XLEN-1:0] w_prod, w_prod_s;
  logic [XLEN-1:0]   w_mul_res;

  assign w_msum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mcand} : {(XLEN+1){1'b0}});
  assign w_mhi_nx  = w_msum[XLEN:1];
  assign w_mlo_nx  = {w_msum[0], r_lo[XLEN-1:1]};
  assign w_prod    = {w_mhi_nx, w_mlo_nx};
  assign w_prod_s  = r_neg ? (~w_prod + 1'b1) : w_prod;
  assign w_mul_res = (r_f3[1:0] == 2'b00) ? w_prod_s[XLEN-1:0] : w_prod_s[2*XLEN-1:XLEN];

  // Restoring divide step: r_hi is the partial remainder, r_lo shifts dividend out and quotient in.
  logic [XLEN:0]   w_rsh, w_diff;
  logic            w_ge;
  logic [XLEN-1:0] w_dhi_nx, w_dlo_nx, w_div_pick, w_div_res;

  assign w_rsh      = {r_hi, r_lo[XLEN-1]};
  assign w_diff     = w_rsh - {1'b0, r_mcand};
  assign w_ge       = ~w_diff[XLEN];
  assign w_dhi_nx   = w_ge ? w_diff[XLEN-1:0] : w_rsh[XLEN-1:0];
  assign w_dlo_nx   = {r_lo[XLEN-2:0], w_ge};
  assign w_div_pick = r_f3[1] ? w_dhi_nx : w_dlo_nx;
  assign w_div_res  = r_neg ? (~w_div_pick + 1'b1) : w_div_pick;

`ifdef ALU_MD_FAST_MUL_EN
  logic signed [XLEN:0]     w_fa, w_fb;
  logic signed [2*XLEN+1:0] w_fprod;
  logic [XLEN-1:0]          w_fast_res;

  assign w_fa       = {w_a_signed & op_a[XLEN-1], op_a};
  assign w_fb       = {w_b_signed & op_b[XLEN-1], op_b};
  assign w_fprod    = w_fa * w_fb;
  assign w_fast_res = (w_f3[1:0] == 2'b00) ? w_fprod[XLEN-1:0] : w_fprod[2*XLEN-1:XLEN];
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_f3     <= '0;
      r_mcand  <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_neg    <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      r_done <= 1'b0;
      if (kill) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (req_valid && is_md) begin
              r_f3  <= w_f3;
              r_cnt <= CW'(XLEN);
              r_hi  <= '0;
              r_neg <= w_neg;
              if (!w_f3[2]) begin
`ifdef ALU_MD_FAST_MUL_EN
                r_result <= w_fast_res;
                r_done   <= 1'b1;
                r_state  <= S_DONE;
`else
                r_mcand <= w_mag_a;
                r_lo    <= w_mag_b;
                r_state <= S_MUL;
`endif
              end else if (w_div_zero || (w_ovf && w_f3[2])) begin
                r_result <= w_special;
                r_done   <= 1'b1;
                r_state  <= S_DONE;
              end else begin
                r_mcand <= w_mag_b;
                r_lo    <= w_mag_a;
                r_state <= S_DIV;
              end
            end
          end
          S_MUL: begin
            r_hi  <= w_mhi_nx;
            r_lo  <= w_mlo_nx;
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == CW'(1)) begin
              r_result <= w_mul_res;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end
          end
          S_DIV: begin
            r_hi  <= w_dhi_nx;
            r_lo  <= w_dlo_nx;
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == CW'(1)) begin
              r_result <= w_div_res;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
